// File: rtl/time_manage_pkg.sv
// time_manage_pkg: constants shared by the acquisition timing generator
// and the receive-side frame synchroniser (states, periods, error bits).
package time_manage_pkg;

    // Frame synchroniser state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Default timing at 100 MHz
    localparam int unsigned FRAME_PERIOD_DEF = 2_500_000;
    localparam int unsigned PERIOD_TOL_DEF   = 100;
    localparam int unsigned ADC_PERIOD_DEF   = 100_000;
    localparam int unsigned VIB_PERIOD_DEF   = 488;
    localparam int unsigned WIN_10MS_DEF     = 1_000_000;
    localparam int unsigned EXP_ADC_DEF      = 25;
    localparam int unsigned EXP_VIB_DEF      = 5122;

    // Bit positions in the sticky error vector
    localparam int ERR_ADC     = 0;
    localparam int ERR_VIB     = 1;
    localparam int ERR_PERIOD  = 2;
    localparam int ERR_TIMEOUT = 3;

endpackage

// File: rtl/frame_period_meter.sv
// frame_period_meter: 24-bit saturating frame period counter with
// tolerance compare and missing-frame timeout detect.
// Ports: clk, rst_n; start (restart count), run (in S_RUN), frame (pulse);
//        meas (clocks in frame incl. pulse cycle), period_err, timeout.
module frame_period_meter
    import time_manage_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = FRAME_PERIOD_DEF,
    parameter int unsigned PERIOD_TOL   = PERIOD_TOL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        run,
    input  logic        frame,
    output logic [23:0] meas,
    output logic        period_err,
    output logic        timeout
);

    localparam logic [31:0] HI_LIM = 32'(FRAME_PERIOD + PERIOD_TOL);
    localparam logic [31:0] NOM    = 32'(FRAME_PERIOD);
    localparam logic [31:0] TOL    = 32'(PERIOD_TOL);

    logic [23:0] cnt;
    logic [31:0] meas_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            if (frame)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 24'd1;
        end
    end

    // The pulse cycle itself belongs to the frame, hence +1
    assign meas   = (cnt == '1) ? cnt : cnt + 24'd1;
    assign meas_w = {8'd0, meas};

    assign period_err = (meas_w > HI_LIM) || (meas_w + TOL < NOM);

    // Fires on the last cycle that could still carry an in-tolerance pulse
    assign timeout = run && !frame && ({8'd0, cnt} + 32'd1 >= HI_LIM);

endmodule

// File: rtl/acq_frame_sync.sv
// acq_frame_sync: locks to the 10 ms window / 25 ms frame sequence, counts
// ADC and vibration start pulses per frame and publishes per-frame results.
// Ports: sys_clk_i, rst_n_i; window/frame/adc/vib pulses; err_clr_i;
//        locked_o, frame_valid_o, frame_cnt_o, adc_cnt_o, vib_cnt_o,
//        period_meas_o, frame_err_o {per,vib,adc}, err_sticky_o {to,per,vib,adc}.
// Macro FRAME_PERIOD_CHECK_EN builds period measurement, check and timeout.
module acq_frame_sync
    import time_manage_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD      = FRAME_PERIOD_DEF,
    parameter int unsigned PERIOD_TOL        = PERIOD_TOL_DEF,
    parameter int unsigned EXP_ADC_PER_FRAME = EXP_ADC_DEF,
    parameter int unsigned EXP_VIB_PER_FRAME = EXP_VIB_DEF
) (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    input  logic        time_period_0_10ms_i,
    input  logic        time_period_25ms_pluse_i,
    input  logic        adc_acq_start_pluse_i,
    input  logic        vibration_acq_start_pluse_i,
    input  logic        err_clr_i,
    output logic        locked_o,
    output logic        frame_valid_o,
    output logic [31:0] frame_cnt_o,
    output logic [7:0]  adc_cnt_o,
    output logic [15:0] vib_cnt_o,
    output logic [23:0] period_meas_o,
    output logic [2:0]  frame_err_o,
    output logic [3:0]  err_sticky_o
);

    localparam logic [7:0]  EXP_ADC = 8'(EXP_ADC_PER_FRAME);
    localparam logic [15:0] EXP_VIB = 16'(EXP_VIB_PER_FRAME);

    logic [1:0]  state;
    logic        first_frame;
    logic [7:0]  adc_run;
    logic [15:0] vib_run;
    logic [7:0]  adc_nx;
    logic [15:0] vib_nx;
    logic        win;
    logic        run;
    logic        close;
    logic [23:0] meas;
    logic        period_err;
    logic        timeout;
    logic [2:0]  ferr;
    logic [3:0]  sticky_set;

    assign win   = time_period_0_10ms_i;
    assign run   = (state == S_RUN);
    assign close = run && !win && time_period_25ms_pluse_i;

`ifdef FRAME_PERIOD_CHECK_EN
    frame_period_meter #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .PERIOD_TOL   (PERIOD_TOL)
    ) u_meter (
        .clk        (sys_clk_i),
        .rst_n      (rst_n_i),
        .start      ((state == S_ARM) && !win),
        .run        (run),
        .frame      (time_period_25ms_pluse_i),
        .meas       (meas),
        .period_err (period_err),
        .timeout    (timeout)
    );
`else
    assign meas       = '0;
    assign period_err = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Saturating increments; a pulse on the close cycle joins the closing frame
    assign adc_nx = (adc_acq_start_pluse_i && adc_run != 8'hFF)
                  ? adc_run + 8'd1 : adc_run;
    assign vib_nx = (vibration_acq_start_pluse_i && vib_run != 16'hFFFF)
                  ? vib_run + 16'd1 : vib_run;

    assign ferr = {period_err && !first_frame,
                   vib_nx != EXP_VIB,
                   adc_nx != EXP_ADC};

    always_comb begin
        sticky_set = '0;
        if (close)
            sticky_set[2:0] = ferr;
        if (run && !win && timeout)
            sticky_set[ERR_TIMEOUT] = 1'b1;
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            first_frame   <= 1'b0;
            adc_run       <= '0;
            vib_run       <= '0;
            locked_o      <= 1'b0;
            frame_valid_o <= 1'b0;
            frame_cnt_o   <= '0;
            adc_cnt_o     <= '0;
            vib_cnt_o     <= '0;
            period_meas_o <= '0;
            frame_err_o   <= '0;
            err_sticky_o  <= '0;
        end else begin
            frame_valid_o <= 1'b0;
            // Set beats clear when both land together
            err_sticky_o  <= (err_clr_i ? 4'd0 : err_sticky_o) | sticky_set;
            unique case (state)
                S_IDLE: begin
                    if (win)
                        state <= S_ARM;
                end
                S_ARM: begin
                    if (!win) begin
                        state       <= S_RUN;
                        locked_o    <= 1'b1;
                        adc_run     <= '0;
                        vib_run     <= '0;
                        first_frame <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (win) begin
                        state    <= S_ARM;
                        locked_o <= 1'b0;
                    end else if (timeout) begin
                        state    <= S_IDLE;
                        locked_o <= 1'b0;
                    end else if (close) begin
                        frame_valid_o <= 1'b1;
                        frame_cnt_o   <= frame_cnt_o + 32'd1;
                        adc_cnt_o     <= adc_nx;
                        vib_cnt_o     <= vib_nx;
                        period_meas_o <= meas;
                        frame_err_o   <= ferr;
                        adc_run       <= '0;
                        vib_run       <= '0;
                        first_frame   <= 1'b0;
                    end else begin
                        adc_run <= adc_nx;
                        vib_run <= vib_nx;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_frame_sync.sv
// tb_acq_frame_sync: directed test of acq_frame_sync with scaled-down
// frame timing (200-clock frames, +/-10 tolerance, 5 ADC / 20 vib pulses).
module tb_acq_frame_sync;

    localparam int unsigned FP  = 200;
    localparam int unsigned TOL = 10;
    localparam int unsigned EA  = 5;
    localparam int unsigned EV  = 20;
`ifdef FRAME_PERIOD_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        win = 1'b0;
    logic        fr = 1'b0;
    logic        adc = 1'b0;
    logic        vib = 1'b0;
    logic        clr = 1'b0;
    logic        locked;
    logic        valid;
    logic [31:0] frame_cnt;
    logic [7:0]  adc_cnt;
    logic [15:0] vib_cnt;
    logic [23:0] period_meas;
    logic [2:0]  frame_err;
    logic [3:0]  sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acq_frame_sync #(
        .FRAME_PERIOD      (FP),
        .PERIOD_TOL        (TOL),
        .EXP_ADC_PER_FRAME (EA),
        .EXP_VIB_PER_FRAME (EV)
    ) dut (
        .sys_clk_i                   (clk),
        .rst_n_i                     (rst_n),
        .time_period_0_10ms_i        (win),
        .time_period_25ms_pluse_i    (fr),
        .adc_acq_start_pluse_i       (adc),
        .vibration_acq_start_pluse_i (vib),
        .err_clr_i                   (clr),
        .locked_o                    (locked),
        .frame_valid_o               (valid),
        .frame_cnt_o                 (frame_cnt),
        .adc_cnt_o                   (adc_cnt),
        .vib_cnt_o                   (vib_cnt),
        .period_meas_o               (period_meas),
        .frame_err_o                 (frame_err),
        .err_sticky_o                (sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // n cycles; last cycle carries the frame pulse when pulse=1
    task automatic frame(input int n, input int na, input int nv,
                         input bit pulse, input bit adc_end);
        int sa = 0;
        int sv = 0;
        int reg_adc = adc_end ? na - 1 : na;
        for (int i = 0; i < n; i++) begin
            adc = 1'b0;
            vib = 1'b0;
            fr  = 1'b0;
            if (adc_end && i == n - 1)
                adc = 1'b1;
            else if (i % 8 == 3 && sa < reg_adc) begin
                adc = 1'b1;
                sa++;
            end
            if (i % 8 == 5 && sv < nv) begin
                vib = 1'b1;
                sv++;
            end
            if (pulse && i == n - 1)
                fr = 1'b1;
            tick();
        end
        adc = 1'b0;
        vib = 1'b0;
        fr  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_locked", 32'(locked), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_adc", 32'(adc_cnt), 0);
        chk("rst_vib", 32'(vib_cnt), 0);
        chk("rst_period", 32'(period_meas), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_sticky", 32'(sticky), 0);
        rst_n = 1'b1;
        tick();

        // Pulse in IDLE is ignored
        fr = 1'b1;
        tick();
        fr = 1'b0;
        chk("idle_valid", 32'(valid), 0);

        // Window, then lock on its fall
        win = 1'b1;
        repeat (5) tick();
        chk("arm_locked", 32'(locked), 0);
        win = 1'b0;
        tick();
        chk("lock_rise", 32'(locked), 1);

        // Frame 1 nominal
        frame(FP, EA, EV, 1, 0);
        chk("f1_valid", 32'(valid), 1);
        chk("f1_fcnt", frame_cnt, 1);
        chk("f1_adc", 32'(adc_cnt), EA);
        chk("f1_vib", 32'(vib_cnt), EV);
        chk("f1_ferr", 32'(frame_err), 0);
        chk("f1_period", 32'(period_meas), EN ? FP : 0);
        tick();
        chk("f1_strobe_low", 32'(valid), 0);
        chk("f1_hold", 32'(adc_cnt), EA);

        // Frame 2 nominal (one cycle already spent)
        frame(FP - 1, EA, EV, 1, 0);
        chk("f2_fcnt", frame_cnt, 2);
        chk("f2_ferr", 32'(frame_err), 0);
        chk("f2_period", 32'(period_meas), EN ? FP : 0);
        chk("f2_sticky", 32'(sticky), 0);

        // Frame 3 short one ADC pulse
        frame(FP, EA - 1, EV, 1, 0);
        chk("f3_fcnt", frame_cnt, 3);
        chk("f3_adc", 32'(adc_cnt), EA - 1);
        chk("f3_ferr", 32'(frame_err), 3'b001);
        chk("f3_sticky", 32'(sticky), 4'b0001);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_sticky", 32'(sticky), 0);

        // Frame 4 long by TOL+1
        frame(FP + TOL, EA, EV, 1, 0);
        chk("f4_fcnt", frame_cnt, 4);
        chk("f4_ferr", 32'(frame_err), EN ? 3'b100 : 3'b000);
        chk("f4_period", 32'(period_meas), EN ? FP + TOL + 1 : 0);
        chk("f4_sticky", 32'(sticky), EN ? 4'b0100 : 4'b0000);

        // Frame 5 short one vib pulse
        frame(FP, EA, EV - 1, 1, 0);
        chk("f5_vib", 32'(vib_cnt), EV - 1);
        chk("f5_ferr", 32'(frame_err), 3'b010);
        chk("f5_sticky", 32'(sticky), EN ? 4'b0110 : 4'b0010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr2_sticky", 32'(sticky), 0);

        // Re-arm mid-frame: partial frame discarded
        frame(50, 2, 5, 0, 0);
        win = 1'b1;
        tick();
        chk("rearm_locked", 32'(locked), 0);
        fr = 1'b1;
        tick();
        fr = 1'b0;
        chk("rearm_valid", 32'(valid), 0);
        chk("rearm_locked2", 32'(locked), 0);
        win = 1'b0;
        tick();
        chk("relock", 32'(locked), 1);
        frame(FP, EA, EV, 1, 0);
        chk("f6_fcnt", frame_cnt, 6);
        chk("f6_adc", 32'(adc_cnt), EA);
        chk("f6_vib", 32'(vib_cnt), EV);
        chk("f6_ferr", 32'(frame_err), 0);

        // First frame after arm: period error suppressed
        win = 1'b1;
        tick();
        win = 1'b0;
        tick();
        frame(FP + TOL + 1, EA, EV, 1, 0);
        chk("f7_fcnt", frame_cnt, 7);
        chk("f7_ferr", 32'(frame_err), 0);
        chk("f7_period", 32'(period_meas), EN ? FP + TOL + 1 : 0);

        // ADC pulse on the frame pulse counts into the closing frame
        frame(FP, EA, EV, 1, 1);
        chk("f8_fcnt", frame_cnt, 8);
        chk("f8_adc", 32'(adc_cnt), EA);
        chk("f8_ferr", 32'(frame_err), 0);
        frame(FP, EA, EV, 1, 0);
        chk("f9_adc", 32'(adc_cnt), EA);
        chk("f9_ferr", 32'(frame_err), 0);
        chk("f9_sticky", 32'(sticky), 0);

        // Missing frame pulse
        frame(FP + TOL - 1, 0, 0, 0, 0);
        chk("to_pre_locked", 32'(locked), 1);
        chk("to_pre_sticky", 32'(sticky), 0);
        tick();
        chk("to_locked", 32'(locked), EN ? 0 : 1);
        chk("to_sticky", 32'(sticky[3]), EN ? 1 : 0);
        fr = 1'b1;
        tick();
        fr = 1'b0;
        chk("to_late_valid", 32'(valid), EN ? 0 : 1);

        // Async reset mid-frame
        win = 1'b1;
        tick();
        win = 1'b0;
        tick();
        frame(30, 2, 3, 0, 0);
        chk("pre_rst_locked", 32'(locked), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_fcnt", frame_cnt, 0);
        chk("arst_adc", 32'(adc_cnt), 0);
        chk("arst_vib", 32'(vib_cnt), 0);
        chk("arst_sticky", 32'(sticky), 0);
        chk("arst_ferr", 32'(frame_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
